// File: rtl/logic_unit_acc.sv
// logic_unit_acc: registered 8-op bitwise unit with multi-beat accumulate mode.
// Optional macro LOGIC_UNIT_FLAGS_EN adds registered parity/zero flags on lout.
module logic_unit_acc #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] lout,
    output logic [CNT_W-1:0] beats
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic             parity,
    output logic             zero
`endif
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx, res_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, beats_nx;
    logic [2:0] op_l;
    logic accept, pop, load;

    // Unary ops (NOT/PASS) act on a; callers pass the operand to keep in a.
    function automatic logic [WIDTH-1:0] bitop(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (o)
            3'b000:  bitop = a & b;
            3'b001:  bitop = a | b;
            3'b010:  bitop = a ^ b;
            3'b011:  bitop = ~(a & b);
            3'b100:  bitop = ~(a | b);
            3'b101:  bitop = ~(a ^ b);
            3'b110:  bitop = ~a;
            default: bitop = a;
        endcase
    endfunction

    always_comb begin
        in_ready = (state != DONE) && (!out_valid || out_ready);
        accept = in_valid && in_ready;
        pop = out_valid && out_ready;
        state_nx = state;
        acc_nx = acc;
        cnt_nx = cnt;
        res_nx = lout;
        beats_nx = beats;
        load = 1'b0;
        if (accept && state == IDLE) begin
            res_nx = bitop(op, x, y);
            beats_nx = CNT_W'(1);
            load = !acc_mode || last;
            if (acc_mode) begin
                acc_nx = res_nx;
                cnt_nx = CNT_W'(1);
                if (!last) state_nx = ACCUM;
            end
        end else if (accept && state == ACCUM) begin
            acc_nx = bitop(op_l, (op_l[2:1] == 2'b11) ? x : acc, x);
            cnt_nx = &cnt ? cnt : cnt + 1'b1;
            if (last) begin
                load = 1'b1;
                res_nx = acc_nx;
                beats_nx = cnt_nx;
                state_nx = DONE;
            end
        end else if (state == DONE && pop) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            lout <= '0;
            beats <= '0;
            acc <= '0;
            cnt <= '0;
            op_l <= '0;
        end else begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            if (accept && state == IDLE && acc_mode) op_l <= op;
            out_valid <= load || (out_valid && !pop);
            if (load) begin
                lout <= res_nx;
                beats <= beats_nx;
            end
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
            zero <= 1'b1;
        end else if (load) begin
            parity <= ^res_nx;
            zero <= (res_nx == '0);
        end
    end
`endif
endmodule
